// File: rtl/aes_decipher.sv
// Byte-serial keystream decipher: pt = data_in ^ inv_sbox[ctr], buffered in a FWFT FIFO.
// Optional feature macro: AES_DECIPHER_FIFO_EN (undefined = single output register stage).
module aes_decipher #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        new_message,
  input  logic [7:0]  key,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  input  logic        out_ready,
  output logic [15:0] byte_count,
  output logic        overflow
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [7:0]  ctr_q, ctr_d;
  logic [7:0]  pt;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_out_q, valid_out_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic        overflow_q, overflow_d;
  logic        push;

  // Keystream uses the counter value before this cycle's load/increment.
  assign pt    = data_in ^ INV_SBOX[ctr_q];
  assign ctr_d = new_message ? key : ctr_q + 8'd1;

  always_comb begin
    if (new_message)
      byte_count_d = {15'd0, push};
    else if (push && !(&byte_count_q))
      byte_count_d = byte_count_q + 16'd1;
    else
      byte_count_d = byte_count_q;
  end

`ifdef AES_DECIPHER_FIFO_EN
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

  occ_t          state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop, drop;

  assign pop  = valid_out_q & out_ready;
  assign push = valid_in & ((state_q != FULL) | pop);
  assign drop = valid_in & ~push;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push) begin
      mem_d[wr_ptr_q] = pt;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;

    unique case (state_q)
      EMPTY:   if (push && !pop) state_d = PARTIAL;
      PARTIAL: begin
        if (push && !pop && count_q == CNT_LAST)
          state_d = FULL;
        else if (pop && !push && count_q == CNT_ONE)
          state_d = EMPTY;
      end
      FULL:    if (pop && !push) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase

    // Head register is loaded from the post-update memory so a write into an empty FIFO shows at once.
    valid_out_d = (count_d != '0);
    data_out_d  = valid_out_d ? mem_d[rd_ptr_d] : '0;

    if (drop)
      overflow_d = 1'b1;
    else if (new_message)
      overflow_d = 1'b0;
    else
      overflow_d = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end
`else
  logic unused_cfg;

  assign push        = valid_in;
  assign valid_out_d = valid_in;
  assign data_out_d  = valid_in ? pt : '0;
  assign overflow_d  = 1'b0;
  assign unused_cfg  = out_ready & (DEPTH > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q        <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ctr_q        <= ctr_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign byte_count = byte_count_q;
  assign overflow   = overflow_q;

endmodule
